// File: rtl/mem_responder.sv
// Dual-port word memory with a streaming loader. The core is held off (busy) while the image
// is loaded, then instruction and data ports are served with registered, read-first reads.
module mem_responder #(
  parameter int unsigned WORD_LEN  = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter bit          START_RUN = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_LEN-1:0]   addr_i,
  output logic [WORD_LEN-1:0]   inst,
  input  logic [WORD_LEN-1:0]   addr_d,
  output logic [WORD_LEN-1:0]   rdata,
  input  logic                  wen,
  input  logic [WORD_LEN/8-1:0] wstrb,
  input  logic [WORD_LEN-1:0]   wdata,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [WORD_LEN-1:0]   load_data,
  input  logic                  load_last,
  output logic                  busy
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned NumLanes = WORD_LEN / 8;

  typedef enum logic [0:0] {StLoad, StRun} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       load_ptr_q, load_ptr_d;
  logic [WORD_LEN-1:0] inst_q, rdata_q;
  logic [WORD_LEN-1:0] mem [DEPTH];

  logic [AW-1:0] idx_i, idx_d;
  logic          ok_i, ok_d;

  // Byte addresses: drop the two lane bits; anything above the array is out of range.
  assign idx_i = addr_i[AW+1:2];
  assign idx_d = addr_d[AW+1:2];
  assign ok_i  = (addr_i >> (AW + 2)) == '0;
  assign ok_d  = (addr_d >> (AW + 2)) == '0;

  always_comb begin
    state_d    = state_q;
    load_ptr_d = load_ptr_q;
    load_ready = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      StLoad: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        if (load_valid) begin
          load_ptr_d = load_ptr_q + AW'(1);
          // Filling the last word ends the load even without load_last.
          if (load_last || (&load_ptr_q)) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= START_RUN ? StRun : StLoad;
      load_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      load_ptr_q <= load_ptr_d;
    end
  end

  // Contents survive reset; no writes are taken while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == StLoad) begin
        if (load_valid) begin
          mem[load_ptr_q] <= load_data;
        end
      end else if (wen && ok_d) begin
        for (int l = 0; l < NumLanes; l++) begin
          if (wstrb[l]) begin
            mem[idx_d][8*l +: 8] <= wdata[8*l +: 8];
          end
        end
      end
    end
  end

  // Registered reads sample the array before this edge's write, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_q  <= '0;
      rdata_q <= '0;
    end else if (state_q == StRun) begin
      inst_q  <= ok_i ? mem[idx_i] : '0;
      rdata_q <= ok_d ? mem[idx_d] : '0;
    end else begin
      inst_q  <= '0;
      rdata_q <= '0;
    end
  end

  assign inst  = inst_q;
  assign rdata = rdata_q;

endmodule
